// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver slice.
//   DATA_W    : character width (8N1 framing)
//   state_t   : receiver FSM state encoding
//   calc_div  : clocks per oversample tick, rounded to nearest
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } state_t;

  // Rounded-to-nearest divider so the tick rate error stays within half a clock.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int rate;
    rate = baud * oversample;
    return (clk_freq + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Line-side and byte-side signals of the UART byte receiver.
//   rx        : asynchronous serial line, idle high (driven by master)
//   Rx_tick   : one-clk strobe, Dout holds a new good byte
//   Dout      : last good received byte
//   frame_err : one-clk strobe, stop bit sampled low
//   busy      : receiver is inside a character
// slave is the receiver side; master is the line driver / byte consumer.
interface uart_byte_receiver_if;
  import uart_pkg::*;

  logic              rx;
  logic              Rx_tick;
  logic [DATA_W-1:0] Dout;
  logic              frame_err;
  logic              busy;

  modport master (output rx, input Rx_tick, Dout, frame_err, busy);
  modport slave  (input rx, output Rx_tick, Dout, frame_err, busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every DIV clocks.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the period (aligns the tick phase to a start edge)
//   tick : registered one-clk pulse
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Period counter; the tick is registered on wrap so the first tick after clr is DIV clocks later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + 1'b1;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_byte_receiver.sv
// UART 8N1 byte receiver: synchronizes rx, oversamples, de-frames characters,
// rejects start-bit glitches and reports stop-bit (framing) errors.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : uart_byte_receiver_if.slave (rx in; Rx_tick, Dout, frame_err, busy out)
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_byte_receiver_if.slave  bus
);

  localparam int                DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic              rx_meta_r, rx_sync_r;
  state_t            state_r, state_n;
  logic [TICK_W-1:0] tick_cnt_r, tick_cnt_n;
  logic [2:0]        bit_cnt_r, bit_cnt_n;
  logic [DATA_W-1:0] shift_r, shift_n;
  logic [DATA_W-1:0] dout_r, dout_n;
  logic              rx_tick_r, rx_tick_n;
  logic              frame_err_r, frame_err_n;
  logic              busy_r, busy_n;
  logic              clr_s;
  logic              tick_s;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Two-flop synchronizer; resets to idle-high so a line held low through reset reads as a new start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state and datapath decode for the framing FSM.
  always_comb begin
    state_n     = state_r;
    tick_cnt_n  = tick_cnt_r;
    bit_cnt_n   = bit_cnt_r;
    shift_n     = shift_r;
    dout_n      = dout_r;
    rx_tick_n   = 1'b0;
    frame_err_n = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tick_cnt_n = '0;
        bit_cnt_n  = 3'd0;
        if (!rx_sync_r) begin
          state_n = ST_START;
          clr_s   = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        // Mid start bit: a line back high means the edge was a glitch.
        if (tick_s && (tick_cnt_r == TICK_MID)) begin
          tick_cnt_n = '0;
          if (!rx_sync_r) begin
            state_n = ST_DATA;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_n = tick_cnt_r + 1'b1;
        end else begin
          tick_cnt_n = tick_cnt_r;
        end
      end
      ST_DATA: begin
        if (tick_s && (tick_cnt_r == TICK_LAST)) begin
          tick_cnt_n = '0;
          shift_n    = {rx_sync_r, shift_r[DATA_W-1:1]};
          if (bit_cnt_r == 3'd7) begin
            bit_cnt_n = 3'd0;
            state_n   = ST_STOP;
          end else begin
            bit_cnt_n = bit_cnt_r + 3'd1;
          end
        end else if (tick_s) begin
          tick_cnt_n = tick_cnt_r + 1'b1;
        end else begin
          tick_cnt_n = tick_cnt_r;
        end
      end
      ST_STOP: begin
        if (tick_s && (tick_cnt_r == TICK_LAST)) begin
          tick_cnt_n = '0;
          if (rx_sync_r) begin
            dout_n    = shift_r;
            rx_tick_n = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = ST_WAIT_HI;
          end
        end else if (tick_s) begin
          tick_cnt_n = tick_cnt_r + 1'b1;
        end else begin
          tick_cnt_n = tick_cnt_r;
        end
      end
      ST_WAIT_HI: begin
        // Break or misaligned frame: resync only once the line returns to idle.
        if (rx_sync_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT_HI;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      tick_cnt_r  <= '0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= '0;
      dout_r      <= '0;
      rx_tick_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      tick_cnt_r  <= tick_cnt_n;
      bit_cnt_r   <= bit_cnt_n;
      shift_r     <= shift_n;
      dout_r      <= dout_n;
      rx_tick_r   <= rx_tick_n;
      frame_err_r <= frame_err_n;
      busy_r      <= busy_n;
    end
  end

  assign bus.Rx_tick   = rx_tick_r;
  assign bus.Dout      = dout_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver at 160 clocks per bit.
module tb_uart_byte_receiver;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_byte_receiver_if bus ();

  uart_byte_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    exp_q.push_back('{is_err: 1'b0, data: d});
  endtask

  task automatic push_err(input logic [7:0] held);
    exp_q.push_back('{is_err: 1'b1, data: held});
  endtask

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic chk_busy);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      hold(d[i], BIT_CLKS);
      if (chk_busy) check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
    end
    hold(stop, BIT_CLKS);
  endtask

  // Monitor: every strobe pops one expected event and compares it.
  always @(negedge clk) begin
    if (!rst && (bus.Rx_tick || bus.frame_err)) begin
      check("strobe_exclusive", {31'd0, bus.Rx_tick & bus.frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got Rx_tick=%0b frame_err=%0b Dout=%0h expected no strobe",
                 bus.Rx_tick, bus.frame_err, bus.Dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, bus.frame_err}, {31'd0, e.is_err});
        check("dout_at_strobe", {24'd0, bus.Dout}, {24'd0, e.data});
      end
    end
  end

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rx_tick", {31'd0, bus.Rx_tick}, 32'd0);
    check("rst_dout", {24'd0, bus.Dout}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    hold(1'b1, 50);

    // 1: single good frame
    push_byte(8'hA5);
    send(8'hA5, 1'b1, 1'b1);
    hold(1'b1, 20);
    check("t1_busy_after", {31'd0, bus.busy}, 32'd0);
    check("t1_dout_after", {24'd0, bus.Dout}, 32'h0000_00A5);

    // 2: back-to-back characters, one stop bit each
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("t2_all_received", exp_q.size(), 32'd0);

    // 3: start glitch shorter than half a bit
    hold(1'b0, 40);
    hold(1'b1, 200);
    check("t3_busy", {31'd0, bus.busy}, 32'd0);
    check("t3_dout_kept", {24'd0, bus.Dout}, 32'h0000_0055);
    push_byte(8'h3C);
    send(8'h3C, 1'b1, 1'b0);
    hold(1'b1, 20);

    // 4: framing error, then recovery
    push_err(8'h3C);
    send(8'h81, 1'b0, 1'b0);
    hold(1'b1, 40);
    check("t4_dout_kept", {24'd0, bus.Dout}, 32'h0000_003C);
    check("t4_busy", {31'd0, bus.busy}, 32'd0);
    push_byte(8'h7E);
    send(8'h7E, 1'b1, 1'b0);
    hold(1'b1, 20);

    // 5: break condition
    push_err(8'h7E);
    hold(1'b0, 30 * BIT_CLKS);
    check("t5_busy_wait_hi", {31'd0, bus.busy}, 32'd1);
    hold(1'b1, 40);
    check("t5_busy_released", {31'd0, bus.busy}, 32'd0);
    push_byte(8'h12);
    send(8'h12, 1'b1, 1'b0);
    hold(1'b1, 20);

    // 6: reset in the middle of bit 4 of 0xC3
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(((8'hC3 >> i) & 8'h01) != 8'h00, BIT_CLKS);
    hold(1'b0, BIT_CLKS / 2);
    rst    = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_rx_tick", {31'd0, bus.Rx_tick}, 32'd0);
    check("t6_rst_dout", {24'd0, bus.Dout}, 32'd0);
    check("t6_rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    hold(1'b1, 200);
    check("t6_idle_after_rst", {31'd0, bus.busy}, 32'd0);
    push_byte(8'hC3);
    send(8'hC3, 1'b1, 1'b0);

    // Drain: bounded wait for any outstanding expected strobes.
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_events", exp_q.size(), 32'd0);
    check("final_dout", {24'd0, bus.Dout}, 32'h0000_00C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
